// File: rtl/snake_move_ctrl.sv
// Snake move scheduler: frame counting, steering latch, sequential self-collision scan
// and circular body buffer with a registered read port for the renderers.
module snake_move_ctrl #(
    parameter int GRID_W      = 20,
    parameter int GRID_H      = 15,
    parameter int MAX_LEN     = 32,
    parameter int MOVE_FRAMES = 8,
    parameter int START_X     = 10,
    parameter int START_Y     = 7,
    parameter int START_LEN   = 3,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int PW = $clog2(MAX_LEN),
    localparam int LW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync_in,
    input  logic [1:0]    dir_in,
    input  logic          dir_valid,
    input  logic          grow,
    input  logic          restart,
    input  logic [PW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          rd_valid,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          busy,
    output logic          game_over
);
    localparam int FW = $clog2(MOVE_FRAMES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_CHECK, S_COMMIT, S_OVER} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] body_x_q [MAX_LEN];
    logic [YW-1:0] body_y_q [MAX_LEN];
    logic [PW-1:0] head_ptr_q;
    logic [XW-1:0] head_x_q, nx_q, nx_d;
    logic [YW-1:0] head_y_q, ny_q, ny_d;
    logic [LW-1:0] length_q, eff_len_q, scan_idx_q;
    logic [1:0]    cur_dir_q, pending_dir_q;
    logic [FW-1:0] frame_cnt_q;
    logic          grow_pending_q, take_grow_q, vs_q;
    logic [XW-1:0] rd_x_q;
    logic [YW-1:0] rd_y_q;
    logic          rd_valid_q;

    logic          frame_edge, move_tick, scan_done, scan_hit, can_grow;
    logic [PW-1:0] rd_ptr, scan_ptr, commit_ptr;

    function automatic logic [XW-1:0] init_x(input int i);
        return (i < START_LEN) ? XW'(START_X - i) : '0;
    endfunction

    function automatic logic [YW-1:0] init_y(input int i);
        return (i < START_LEN) ? YW'(START_Y) : '0;
    endfunction

    assign frame_edge = vsync_in & ~vs_q;
    assign move_tick  = (state_q == S_IDLE) && frame_edge
                        && (frame_cnt_q == FW'(MOVE_FRAMES - 1));
    assign rd_ptr     = head_ptr_q + rd_idx;
    assign scan_ptr   = head_ptr_q + scan_idx_q[PW-1:0];
    assign commit_ptr = head_ptr_q - 1'b1;
    assign scan_done  = (scan_idx_q == eff_len_q);
    assign scan_hit   = (body_x_q[scan_ptr] == nx_q) && (body_y_q[scan_ptr] == ny_q);
    assign can_grow   = grow_pending_q && (length_q < LW'(MAX_LEN));

    // Candidate head cell on the torus, derived from the direction that CALC latches.
    always_comb begin
        nx_d = head_x_q;
        ny_d = head_y_q;
        case (pending_dir_q)
            2'd0:    ny_d = (head_y_q == '0) ? YW'(GRID_H - 1) : head_y_q - 1'b1;
            2'd1:    nx_d = (head_x_q == XW'(GRID_W - 1)) ? '0 : head_x_q + 1'b1;
            2'd2:    ny_d = (head_y_q == YW'(GRID_H - 1)) ? '0 : head_y_q + 1'b1;
            default: nx_d = (head_x_q == '0) ? XW'(GRID_W - 1) : head_x_q - 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (move_tick) state_d = S_CALC;
            S_CALC:   state_d = S_CHECK;
            S_CHECK:  begin
                if (scan_done)     state_d = S_COMMIT;
                else if (scan_hit) state_d = S_OVER;
            end
            S_COMMIT: state_d = S_IDLE;
            S_OVER:   state_d = S_OVER;
            default:  state_d = S_IDLE;
        endcase
        if (restart) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q           <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x_q[i] <= init_x(i);
                body_y_q[i] <= init_y(i);
            end
            head_ptr_q     <= '0;
            head_x_q       <= XW'(START_X);
            head_y_q       <= YW'(START_Y);
            length_q       <= LW'(START_LEN);
            cur_dir_q      <= 2'd1;
            pending_dir_q  <= 2'd1;
            frame_cnt_q    <= '0;
            grow_pending_q <= 1'b0;
            take_grow_q    <= 1'b0;
            nx_q           <= '0;
            ny_q           <= '0;
            eff_len_q      <= '0;
            scan_idx_q     <= '0;
            rd_x_q         <= '0;
            rd_y_q         <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            vs_q <= vsync_in;
            if (restart) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    body_x_q[i] <= init_x(i);
                    body_y_q[i] <= init_y(i);
                end
                head_ptr_q     <= '0;
                head_x_q       <= XW'(START_X);
                head_y_q       <= YW'(START_Y);
                length_q       <= LW'(START_LEN);
                cur_dir_q      <= 2'd1;
                pending_dir_q  <= 2'd1;
                frame_cnt_q    <= '0;
                grow_pending_q <= 1'b0;
                take_grow_q    <= 1'b0;
                scan_idx_q     <= '0;
                rd_x_q         <= '0;
                rd_y_q         <= '0;
                rd_valid_q     <= 1'b0;
            end else begin
                rd_x_q     <= body_x_q[rd_ptr];
                rd_y_q     <= body_y_q[rd_ptr];
                rd_valid_q <= ({1'b0, rd_idx} < length_q);
                // Reversal is judged against the direction actually travelled.
                if (state_q != S_OVER) begin
                    if (dir_valid && (dir_in != (cur_dir_q ^ 2'b10))) pending_dir_q <= dir_in;
                    if (grow) grow_pending_q <= 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (frame_edge) frame_cnt_q <= move_tick ? '0 : frame_cnt_q + 1'b1;
                    end
                    S_CALC: begin
                        cur_dir_q      <= pending_dir_q;
                        nx_q           <= nx_d;
                        ny_q           <= ny_d;
                        scan_idx_q     <= '0;
                        take_grow_q    <= can_grow;
                        eff_len_q      <= can_grow ? length_q : length_q - 1'b1;
                        // Grow is consumed here, even when saturated; a pulse now counts next move.
                        grow_pending_q <= grow;
                    end
                    S_CHECK: begin
                        if (!scan_done && !scan_hit) scan_idx_q <= scan_idx_q + 1'b1;
                    end
                    S_COMMIT: begin
                        head_ptr_q           <= commit_ptr;
                        body_x_q[commit_ptr] <= nx_q;
                        body_y_q[commit_ptr] <= ny_q;
                        head_x_q             <= nx_q;
                        head_y_q             <= ny_q;
                        if (take_grow_q) length_q <= length_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;
    assign rd_valid  = rd_valid_q;
    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign length    = length_q;
    assign busy      = (state_q == S_CALC) || (state_q == S_CHECK) || (state_q == S_COMMIT);
    assign game_over = (state_q == S_OVER);

endmodule
